// File: rtl/arb_pkg.sv
// Shared types and defaults for the dmem arbiter.
package arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_HOST} owner_t;
    localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Round-robin winner selection with a bounded burst for the owner.
module rr_pick
    import arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic       c_req,
    input  logic       h_req,
    input  owner_t     owner,
    input  owner_t     last,
    input  logic [7:0] burst_cnt,
    output owner_t     win
);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    always_comb begin
        win = OWN_NONE;
        case ({c_req, h_req})
            2'b10: win = OWN_CORE;
            2'b01: win = OWN_HOST;
            2'b11: begin
                if (owner != OWN_NONE && burst_cnt < BURST_MAX)
                    win = owner;
                else
                    win = (last == OWN_CORE) ? OWN_HOST : OWN_CORE;
            end
            default: win = OWN_NONE;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between core and host: grant, steering,
// read return and conflict counting.
module dmem_arbiter
    import arb_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_in,
    output logic          dm_we,
    input  logic [DW-1:0] dm_out,
    output logic [7:0]    conflict_cnt
);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    owner_t        owner;
    owner_t        last;
    owner_t        pick;
    owner_t        win;
    logic [7:0]    burst_cnt;
    logic          rd_c;
    logic          rd_h;
    logic [DW-1:0] c_hold;
    logic [DW-1:0] h_hold;

    rr_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .c_req     (c_req),
        .h_req     (h_req),
        .owner     (owner),
        .last      (last),
        .burst_cnt (burst_cnt),
        .win       (pick)
    );

    // Reset masks the grant so no write can reach memory in a reset cycle.
    assign win   = rst_n ? pick : OWN_NONE;
    assign c_gnt = (win == OWN_CORE);
    assign h_gnt = (win == OWN_HOST);

    always_comb begin
        dm_addr = '0;
        dm_in   = '0;
        dm_we   = 1'b0;
        if (c_gnt) begin
            dm_addr = c_addr;
            dm_in   = c_wdata;
            dm_we   = c_we;
        end else if (h_gnt) begin
            dm_addr = h_addr;
            dm_in   = h_wdata;
            dm_we   = h_we;
        end
    end

    // Read data passes through in its return cycle, then is held.
    assign c_rvalid = rd_c & rst_n;
    assign h_rvalid = rd_h & rst_n;
    assign c_rdata  = c_rvalid ? dm_out : c_hold;
    assign h_rdata  = h_rvalid ? dm_out : h_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner        <= OWN_NONE;
            last         <= OWN_HOST;
            burst_cnt    <= 8'd0;
            rd_c         <= 1'b0;
            rd_h         <= 1'b0;
            c_hold       <= '0;
            h_hold       <= '0;
            conflict_cnt <= 8'd0;
        end else begin
            if (win == OWN_NONE) begin
                owner <= OWN_NONE;
            end else begin
                owner <= win;
                last  <= win;
                if (win != owner)
                    burst_cnt <= 8'd1;
                else if (burst_cnt < BURST_MAX)
                    burst_cnt <= burst_cnt + 8'd1;
            end
            rd_c <= c_gnt & ~c_we;
            rd_h <= h_gnt & ~h_we;
            if (rd_c)
                c_hold <= dm_out;
            if (rd_h)
                h_hold <= dm_out;
            if (c_req && h_req && conflict_cnt != 8'hFF)
                conflict_cnt <= conflict_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a dmem model and a
// read-return scoreboard.
module tb_dmem_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       c_req, c_we, h_req, h_we;
    logic [7:0] c_addr, c_wdata, h_addr, h_wdata;
    logic       c_gnt, c_rvalid, h_gnt, h_rvalid;
    logic [7:0] c_rdata, h_rdata;
    logic [7:0] dm_addr, dm_in, dm_out, conflict_cnt;
    logic       dm_we;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] qc[$];
    logic [7:0] qh[$];
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .c_req        (c_req),
        .c_we         (c_we),
        .c_addr       (c_addr),
        .c_wdata      (c_wdata),
        .c_gnt        (c_gnt),
        .c_rvalid     (c_rvalid),
        .c_rdata      (c_rdata),
        .h_req        (h_req),
        .h_we         (h_we),
        .h_addr       (h_addr),
        .h_wdata      (h_wdata),
        .h_gnt        (h_gnt),
        .h_rvalid     (h_rvalid),
        .h_rdata      (h_rdata),
        .dm_addr      (dm_addr),
        .dm_in        (dm_in),
        .dm_we        (dm_we),
        .dm_out       (dm_out),
        .conflict_cnt (conflict_cnt)
    );

    // Synchronous single-port memory: read data valid the next cycle.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h33;
    end
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_in;
        dm_out <= mem[dm_addr];
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r,
                         input logic cr, input logic cw,
                         input logic [7:0] ca, input logic [7:0] cd,
                         input logic hr, input logic hw,
                         input logic [7:0] ha, input logic [7:0] hd);
        @(negedge clk);
        rst_n = r;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Monitor: every rvalid must match the oldest expected read.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (c_rvalid) begin
                if (qc.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL c_rvalid: unexpected pulse, data %0h", c_rdata);
                end else begin
                    chk("c_rdata", c_rdata, qc.pop_front());
                end
            end
            if (h_rvalid) begin
                if (qh.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL h_rvalid: unexpected pulse, data %0h", h_rdata);
                end else begin
                    chk("h_rdata", h_rdata, qh.pop_front());
                end
            end
        end
    end

    initial begin
        logic [8:0] hp;
        rst_n = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
        h_req = 1'b0; h_we = 1'b0; h_addr = 8'h00; h_wdata = 8'h00;

        // Reset held with both sides requesting writes
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'h80, 8'hC0, 1'b1, 1'b1, 8'h90, 8'hD0);
            chk("rst c_gnt", {7'd0, c_gnt}, 8'd0);
            chk("rst h_gnt", {7'd0, h_gnt}, 8'd0);
            chk("rst dm_we", {7'd0, dm_we}, 8'd0);
            chk("rst conflict", conflict_cnt, 8'd0);
        end

        // Continuous contention: C,C,C,C,H,H,H,H,C
        hp = 9'b0_1111_0000;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b1, 8'h80, 8'hC0, 1'b1, 1'b1, 8'h90, 8'hD0);
            chk("tie conflict", conflict_cnt, 8'(i));
            chk("tie c_gnt", {7'd0, c_gnt}, {7'd0, ~hp[i]});
            chk("tie h_gnt", {7'd0, h_gnt}, {7'd0, hp[i]});
            chk("tie dm_addr", dm_addr, hp[i] ? 8'h90 : 8'h80);
            chk("tie dm_in", dm_in, hp[i] ? 8'hD0 : 8'hC0);
        end
        idle();
        chk("idle gnt", {6'd0, c_gnt, h_gnt}, 8'd0);
        chk("idle dm_addr", dm_addr, 8'h00);
        chk("idle dm_we", {7'd0, dm_we}, 8'd0);
        chk("idle conflict", conflict_cnt, 8'd9);

        // Core alone: write 0x5A to 0x10, then read it back
        drive(1'b1, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("cw c_gnt", {7'd0, c_gnt}, 8'd1);
        chk("cw dm_we", {7'd0, dm_we}, 8'd1);
        chk("cw dm_addr", dm_addr, 8'h10);
        chk("cw dm_in", dm_in, 8'h5A);
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("cr c_gnt", {7'd0, c_gnt}, 8'd1);
        chk("cr dm_we", {7'd0, dm_we}, 8'd0);
        qc.push_back(8'h5A);
        idle();
        chk("cr c_rvalid", {7'd0, c_rvalid}, 8'd1);

        // Host alone for 10 cycles: writes 0x60+i to 0x30+i
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00,
                  1'b1, 1'b1, 8'(8'h30 + i), 8'(8'h60 + i));
            chk("host h_gnt", {7'd0, h_gnt}, 8'd1);
        end

        // Host read overlaps the next core write
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        chk("hr h_gnt", {7'd0, h_gnt}, 8'd1);
        qh.push_back(8'h33);
        drive(1'b1, 1'b1, 1'b1, 8'h21, 8'h44, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("ovl c_gnt", {7'd0, c_gnt}, 8'd1);
        chk("ovl h_rvalid", {7'd0, h_rvalid}, 8'd1);
        chk("ovl h_rdata", h_rdata, 8'h33);
        drive(1'b1, 1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("cr21 c_gnt", {7'd0, c_gnt}, 8'd1);
        qc.push_back(8'h44);
        idle();
        idle();
        chk("hold c_rdata", c_rdata, 8'h44);
        chk("hold h_rdata", h_rdata, 8'h33);
        chk("hold c_rvalid", {7'd0, c_rvalid}, 8'd0);

        // Core reads back a host-written location
        drive(1'b1, 1'b1, 1'b0, 8'h35, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        qc.push_back(8'h65);
        idle();

        // Reset right after a core read grant suppresses its rvalid
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rr c_gnt", {7'd0, c_gnt}, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rr c_rvalid", {7'd0, c_rvalid}, 8'd0);
        drive(1'b1, 1'b1, 1'b1, 8'h80, 8'hC0, 1'b1, 1'b1, 8'h90, 8'hD0);
        chk("rr tie c_gnt", {7'd0, c_gnt}, 8'd1);
        chk("rr tie h_gnt", {7'd0, h_gnt}, 8'd0);
        chk("rr conflict", conflict_cnt, 8'd0);
        idle();
        idle();

        chk("qc drained", 8'(qc.size()), 8'd0);
        chk("qh drained", 8'(qh.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
